branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. It predicts direction and target for the current fetch PC. It is trained by the resolved outcome that the EX-stage branch comparator produces. It also detects mispredictions and supplies the redirect PC used to flush IF/ID.

## Interface

Parameters:
- INDEX_BITS, 4, log2 of entry count (16 entries); index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2]

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- if_pc  input  32  PC being fetched
- pred_taken  output  1  predicted taken for if_pc
- pred_target  output  32  predicted next PC for if_pc
- ex_valid  input  1  a conditional branch is resolving in EX this cycle
- ex_pc  input  32  PC of the resolving branch
- ex_taken  input  1  resolved direction from the branch comparator
- ex_target  input  32  computed taken target (pc + B-immediate)
- ex_pred_taken  input  1  prediction carried down the pipe with this branch
- ex_pred_target  input  32  predicted next PC carried down the pipe
- mispredict  output  1  flush IF/ID and redirect this cycle
- redirect_pc  output  32  correct next PC when mispredict=1
- branch_count  output  32  resolved-branch counter (see Configuration)
- mispredict_count  output  32  misprediction counter (see Configuration)

## Operation

- Entry state: valid (1b), tag, target (32b), ctr (2b). Storage is registers, not RAM.
- Lookup is combinational from the registered table.
  - hit = valid[idx] && tag match.
  - If hit && ctr[1]: pred_taken=1 and pred_target=stored target.
  - Otherwise: pred_taken=0 and pred_target=if_pc+4 (32-bit wrap).
- Update happens at the clock edge when ex_valid=1, indexed by ex_pc.
  - Hit, taken: ctr saturating increment (11 stays 11); target ← ex_target.
  - Hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss, taken: allocate and overwrite the entry; valid=1, tag, target=ex_target, ctr=10.
  - Miss, not taken: no change; not-taken branches are never allocated.
- mispredict is combinational: ex_valid && (ex_taken≠ex_pred_taken || (ex_taken && ex_target≠ex_pred_target)).
- redirect_pc = ex_taken ? ex_target : ex_pc+4. When mispredict=0, redirect_pc is don't-care but must still be driven by the same equation.
- ex_valid=0: no table write and no counter change; mispredict=0.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- A taken branch whose PC aliases an existing entry with a different tag evicts that entry.

## Timing

- Reset (synchronous, active-high):
  - All valid and tag bits are cleared.
  - All ctr values are set to 01.
  - Targets are set to 0.
  - Stat counters are set to 0.
  - Combinational outputs follow from this cleared state: pred_taken=0, pred_target=if_pc+4.
- Prediction latency is 0 cycles: outputs are valid in the same cycle as if_pc.
- An update is visible to lookups from the cycle after the ex_valid edge.
- When the same index is read and written in one cycle, lookup returns the pre-update contents (no bypass).
- reset and ex_valid in the same cycle: reset wins, and no update is applied.
- mispredict and redirect_pc are valid in the same cycle as ex_valid. The pipeline flushes at the next edge.

## Configuration

- BP_STATS_EN defined:
  - branch_count increments by 1 on every edge with ex_valid=1.
  - mispredict_count increments by 1 on every edge with mispredict=1.
  - Both counters wrap 0xFFFFFFFF→0 and clear on reset.
- BP_STATS_EN undefined: counter registers are not built, and both ports are tied to 32'h0.
- Prediction and update behaviour is identical in both builds.

## Test plan

- Cold table, reset then if_pc=0x100:
  - Required: pred_taken=0, pred_target=0x104.
  - Resolve ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0: mispredict=1 and redirect_pc=0x80.
  - Next cycle, if_pc=0x100 gives pred_taken=1, pred_target=0x80.
- Saturation, starting from the 0x100 entry (ctr=10):
  - Two taken resolves: ctr=11.
  - One not-taken resolve: ctr=10, still predicts taken.
  - A second not-taken: ctr=01, pred_taken=0, pred_target=0x104.
  - Three further not-taken: ctr stays 00.
- Alias eviction:
  - Entry 0x100 is valid.
  - Resolve taken ex_pc=0x140 (same index, different tag), target 0x200.
  - Next cycle: if_pc=0x100 misses (pred_target=0x104); if_pc=0x140 predicts 0x200.
- Target-only mispredict:
  - ex_taken=1, ex_pred_taken=1, ex_target=0x300, ex_pred_target=0x2FC.
  - Required: mispredict=1, redirect_pc=0x300, and the stored target updates to 0x300.
- Same-cycle read/write and reset priority:
  - if_pc=ex_pc=0x100 while allocating: lookup shows the old entry that cycle, the new entry the next cycle.
  - reset with ex_valid=1: table is cleared, with no allocation.
- Stats (BP_STATS_EN):
  - 5 resolves, of which 2 mispredicted: branch_count=5, mispredict_count=2.
  - Without the macro: both counters read 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/EX port bundle of the branch predictor: fetch-PC lookup,
// EX-stage resolve, redirect and statistics outputs.
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc, branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, trained from EX.
// Define BP_STATS_EN to build the resolved-branch and misprediction counters.
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx_s, ex_idx_s;
    logic [TAG_W-1:0]      if_tag_s, ex_tag_s;
    logic                  if_hit_s, ex_hit_s;
    logic                  unused_ok_s;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    assign if_idx_s    = bp.if_pc[INDEX_BITS+1:2];
    assign if_tag_s    = bp.if_pc[31:INDEX_BITS+2];
    assign ex_idx_s    = bp.ex_pc[INDEX_BITS+1:2];
    assign ex_tag_s    = bp.ex_pc[31:INDEX_BITS+2];
    assign if_hit_s    = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
    assign ex_hit_s    = valid_q[ex_idx_s] && (tag_q[ex_idx_s] == ex_tag_s);
    assign unused_ok_s = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};

    // Fetch lookup from the registered table; no bypass of the pending write
    always_comb begin
        bp.pred_taken  = 1'b0;
        bp.pred_target = bp.if_pc + 32'd4;
        if (if_hit_s && ctr_q[if_idx_s][1]) begin
            bp.pred_taken  = 1'b1;
            bp.pred_target = target_q[if_idx_s];
        end else begin
            bp.pred_taken  = 1'b0;
            bp.pred_target = bp.if_pc + 32'd4;
        end
    end

    // Misprediction detect and correct next-PC
    always_comb begin
        bp.mispredict  = bp.ex_valid &&
                         ((bp.ex_taken != bp.ex_pred_taken) ||
                          (bp.ex_taken && (bp.ex_target != bp.ex_pred_target)));
        bp.redirect_pc = bp.ex_taken ? bp.ex_target : (bp.ex_pc + 32'd4);
    end

    // Table training; not-taken misses are never allocated
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bp.ex_valid) begin
            if (ex_hit_s) begin
                if (bp.ex_taken) begin
                    ctr_d[ex_idx_s]    = sat_inc(ctr_q[ex_idx_s]);
                    target_d[ex_idx_s] = bp.ex_target;
                end else begin
                    ctr_d[ex_idx_s]    = sat_dec(ctr_q[ex_idx_s]);
                end
            end else if (bp.ex_taken) begin
                valid_d[ex_idx_s]  = 1'b1;
                tag_d[ex_idx_s]    = ex_tag_s;
                target_d[ex_idx_s] = bp.ex_target;
                ctr_d[ex_idx_s]    = 2'b10;
            end else begin
                valid_d = valid_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Table registers; reset leaves counters weak-not-taken
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] misp_cnt_q, misp_cnt_d;

    // Statistic next-state, free-running wrap
    always_comb begin
        if (bp.ex_valid) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end else begin
            branch_cnt_d = branch_cnt_q;
        end
        if (bp.mispredict) begin
            misp_cnt_d = misp_cnt_q + 32'd1;
        end else begin
            misp_cnt_d = misp_cnt_q;
        end
    end

    // Statistic registers
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_q <= 32'h0;
            misp_cnt_q   <= 32'h0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            misp_cnt_q   <= misp_cnt_d;
        end
    end

    assign bp.branch_count     = branch_cnt_q;
    assign bp.mispredict_count = misp_cnt_q;
`else
    assign bp.branch_count     = 32'h0;
    assign bp.mispredict_count = 32'h0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: per-cycle expectations are queued as
// stimulus is driven and popped when the combinational outputs settle.
module tb_branch_predictor;
    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;
    int   n_br;
    int   n_misp;

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic        misp;
        logic [31:0] redir;
    } exp_t;

    exp_t exp_q[$];

    branch_predictor_if bp_if ();

    branch_predictor #(.INDEX_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    endtask

    task automatic step(input logic rst, input logic [31:0] if_pc,
                        input logic exv, input logic [31:0] expc, input logic ext,
                        input logic [31:0] extgt, input logic expt, input logic [31:0] exptgt,
                        input logic e_pt, input logic [31:0] e_ptgt,
                        input logic e_misp, input logic [31:0] e_redir);
        exp_t e;
        @(negedge clk);
        reset                = rst;
        bp_if.if_pc          = if_pc;
        bp_if.ex_valid       = exv;
        bp_if.ex_pc          = expc;
        bp_if.ex_taken       = ext;
        bp_if.ex_target      = extgt;
        bp_if.ex_pred_taken  = expt;
        bp_if.ex_pred_target = exptgt;
        e.pt = e_pt; e.ptgt = e_ptgt; e.misp = e_misp; e.redir = e_redir;
        exp_q.push_back(e);
        if (rst) begin
            n_br   = 0;
            n_misp = 0;
        end else begin
            if (exv)    n_br++;
            if (e_misp) n_misp++;
        end
        #1;
        n_total++;
        assert (exp_q.size() > 0) n_pass++;
        else $error("FAIL scoreboard_empty observed=%0d expected=1", exp_q.size());
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pred_taken",  {31'h0, bp_if.pred_taken}, {31'h0, e.pt});
            chk("pred_target", bp_if.pred_target, e.ptgt);
            chk("mispredict",  {31'h0, bp_if.mispredict}, {31'h0, e.misp});
            chk("redirect_pc", bp_if.redirect_pc, e.redir);
        end
    endtask

    task automatic idle(input logic rst, input logic [31:0] if_pc,
                        input logic e_pt, input logic [31:0] e_ptgt);
        step(rst, if_pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, e_pt, e_ptgt, 1'b0, 32'h4);
    endtask

    task automatic chk_stats(input string name);
`ifdef BP_STATS_EN
        chk({name, "_branch_count"},     bp_if.branch_count,     n_br);
        chk({name, "_mispredict_count"}, bp_if.mispredict_count, n_misp);
`else
        chk({name, "_branch_count"},     bp_if.branch_count,     32'h0);
        chk({name, "_mispredict_count"}, bp_if.mispredict_count, 32'h0);
`endif
    endtask

    initial begin
        n_total = 0; n_pass = 0; n_br = 0; n_misp = 0;
        reset = 1'b1;
        bp_if.if_pc = 32'h0; bp_if.ex_valid = 1'b0; bp_if.ex_pc = 32'h0;
        bp_if.ex_taken = 1'b0; bp_if.ex_target = 32'h0;
        bp_if.ex_pred_taken = 1'b0; bp_if.ex_pred_target = 32'h0;

        // Reset and cold table
        idle(1'b1, 32'h100, 1'b0, 32'h104);
        idle(1'b1, 32'h100, 1'b0, 32'h104);
        idle(1'b0, 32'h100, 1'b0, 32'h104);
        chk_stats("reset");
        // Allocate: same-cycle lookup still shows the miss
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h80);
        idle(1'b0, 32'h100, 1'b1, 32'h80);
        // Saturate up: 10 -> 11 -> 11
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
        // Walk down: 11 -> 10 (still taken) -> 01 (not taken)
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
        idle(1'b0, 32'h100, 1'b1, 32'h80);
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
        idle(1'b0, 32'h100, 1'b0, 32'h104);
        // Three more not-taken: floor at 00
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h104);
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h104);
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h104);
        // One taken from 00 gives 01: still not taken
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h80);
        idle(1'b0, 32'h100, 1'b0, 32'h104);
        step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h80);
        idle(1'b0, 32'h100, 1'b1, 32'h80);
        // Alias eviction by 0x140
        step(1'b0, 32'h100, 1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144, 1'b1, 32'h80, 1'b1, 32'h200);
        idle(1'b0, 32'h100, 1'b0, 32'h104);
        idle(1'b0, 32'h140, 1'b1, 32'h200);
        // Target-only mispredict and retarget
        step(1'b0, 32'h140, 1'b1, 32'h140, 1'b1, 32'h300, 1'b1, 32'h2FC, 1'b1, 32'h200, 1'b1, 32'h300);
        idle(1'b0, 32'h140, 1'b1, 32'h300);
        step(1'b0, 32'h140, 1'b1, 32'h140, 1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 32'h300);
        // Fall-through wraps at the top of the address space
        idle(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);
        chk_stats("run");
        // Reset beats a same-cycle allocate of 0x180
        step(1'b1, 32'h140, 1'b1, 32'h180, 1'b1, 32'h400, 1'b0, 32'h184, 1'b1, 32'h300, 1'b1, 32'h400);
        idle(1'b0, 32'h180, 1'b0, 32'h184);
        idle(1'b0, 32'h140, 1'b0, 32'h144);
        chk_stats("after_reset");
        // Five resolves, two mispredicted
        step(1'b0, 32'h500, 1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h504, 1'b0, 32'h504, 1'b1, 32'h600);
        step(1'b0, 32'h500, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 32'h600, 1'b1, 32'h600, 1'b0, 32'h600);
        step(1'b0, 32'h500, 1'b1, 32'h500, 1'b0, 32'h600, 1'b1, 32'h600, 1'b1, 32'h600, 1'b1, 32'h504);
        step(1'b0, 32'h500, 1'b1, 32'h500, 1'b0, 32'h600, 1'b0, 32'h504, 1'b1, 32'h600, 1'b0, 32'h504);
        step(1'b0, 32'h500, 1'b1, 32'h500, 1'b0, 32'h600, 1'b0, 32'h504, 1'b0, 32'h504, 1'b0, 32'h504);
        idle(1'b0, 32'h500, 1'b0, 32'h504);
        chk_stats("five");
`ifdef BP_STATS_EN
        chk("five_branch_const", bp_if.branch_count, 32'd5);
        chk("five_misp_const",   bp_if.mispredict_count, 32'd2);
`endif
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
